// File: rtl/axis_byte_realigner.sv
// -----------------------------------------------------------------------------
// axis_byte_realigner
//
// Byte-lane merge engine for a packed AXI-Stream that has been shifted up by a
// fixed number of bytes (SHIFT_BYTES). It holds the SHIFT_BYTES bytes that
// spilled past the top of the previous beat (the residue), and combines them
// with the low lanes of the current input beat to form one output beat.
//
// - With SHIFT_BYTES == 0 it is a pass-through and holds no state.
// - The residue can be preloaded from an arbitrary source, for example the
//   tail of a header, before the first payload beat arrives.
//
// Ports:
//   clk, sresetn     clock, synchronous active-low reset
//   preload          load residue from preload_data[SHIFT_BYTES*8-1:0]
//   preload_data     residue source (only the low SHIFT_BYTES lanes are used)
//   advance          input beat consumed: residue <= top SHIFT_BYTES lanes
//   in_data/in_keep  current input beat
//   merged_data/keep residue in the low lanes, input low lanes above it
//   spill            input beat has bytes that do not fit in the merged beat
//   flush_data/keep  residue on its own, for the trailing flush beat
// -----------------------------------------------------------------------------
module axis_byte_realigner #(
    parameter int AXIS_BYTES  = 1,
    parameter int SHIFT_BYTES = 0
) (
    input  logic                    clk,
    input  logic                    sresetn,
    input  logic                    preload,
    input  logic [AXIS_BYTES*8-1:0] preload_data,
    input  logic                    advance,
    input  logic [AXIS_BYTES*8-1:0] in_data,
    input  logic [AXIS_BYTES-1:0]   in_keep,
    output logic [AXIS_BYTES*8-1:0] merged_data,
    output logic [AXIS_BYTES-1:0]   merged_keep,
    output logic                    spill,
    output logic [AXIS_BYTES*8-1:0] flush_data,
    output logic [AXIS_BYTES-1:0]   flush_keep
);

    localparam int DW = AXIS_BYTES * 8;

    generate
        if (SHIFT_BYTES == 0) begin : g_pass
            // Aligned case: nothing is ever carried between beats.
            logic unused_r0;
            assign unused_r0   = ^{clk, sresetn, preload, preload_data, advance};
            assign merged_data = in_data;
            assign merged_keep = in_keep;
            assign spill       = 1'b0;
            assign flush_data  = '0;
            assign flush_keep  = '0;
        end else begin : g_shift
            localparam int RB = SHIFT_BYTES * 8;
            localparam int LB = AXIS_BYTES - SHIFT_BYTES;

            logic [RB-1:0]          res_data_reg;
            logic [SHIFT_BYTES-1:0] res_keep_reg;
            logic                   unused_preload;

            // Only the low SHIFT_BYTES lanes of the preload word are residue.
            assign unused_preload = ^preload_data[DW-1:RB];

            always_ff @(posedge clk) begin
                if (!sresetn) begin
                    res_data_reg <= '0;
                    res_keep_reg <= '0;
                end else if (preload) begin
                    res_data_reg <= preload_data[RB-1:0];
                    res_keep_reg <= '0;
                end else if (advance) begin
                    res_data_reg <= in_data[DW-1 -: RB];
                    res_keep_reg <= in_keep[AXIS_BYTES-1 -: SHIFT_BYTES];
                end
            end

            assign merged_data = {in_data[LB*8-1:0], res_data_reg};
            assign merged_keep = {in_keep[LB-1:0], {SHIFT_BYTES{1'b1}}};
            // With a packed stream, any kept byte in the top lanes means the
            // beat overflows the merged output and a flush beat must follow.
            assign spill       = |in_keep[AXIS_BYTES-1 -: SHIFT_BYTES];
            assign flush_data  = {{(LB*8){1'b0}}, res_data_reg};
            assign flush_keep  = {{LB{1'b0}}, res_keep_reg};
        end
    endgenerate

endmodule

// File: rtl/axis_header_prepender.sv
// -----------------------------------------------------------------------------
// axis_header_prepender
//
// Prepends a fixed-length header, supplied as a parallel sideband word with its
// own valid/ready handshake, to a packed AXI-Stream payload. The output is one
// packed packet: header bytes first (byte 0 from header_i_tdata[7:0] leads),
// then payload bytes, re-aligned across beat boundaries when the header length
// is not a multiple of the bus width.
//
// Ports:
//   clk, sresetn                 clock, synchronous active-low reset
//   header_i_tvalid/tready/tdata header sideband handshake and word
//   axis_i_*                     packed payload stream (keep all ones except
//                                on the tlast beat, which has k>=1 low bytes)
//   axis_o_*                     packed output stream, single register stage
// -----------------------------------------------------------------------------
module axis_header_prepender #(
    parameter int AXIS_BYTES          = 1,
    parameter int AXIS_USER_BITS      = 1,
    parameter int HEADER_LENGTH_BYTES = 1
) (
    input  logic                             clk,
    input  logic                             sresetn,
    input  logic                             header_i_tvalid,
    output logic                             header_i_tready,
    input  logic [HEADER_LENGTH_BYTES*8-1:0] header_i_tdata,
    input  logic                             axis_i_tvalid,
    output logic                             axis_i_tready,
    input  logic                             axis_i_tlast,
    input  logic [AXIS_BYTES-1:0]            axis_i_tkeep,
    input  logic [AXIS_BYTES*8-1:0]          axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0]        axis_i_tuser,
    output logic                             axis_o_tvalid,
    input  logic                             axis_o_tready,
    output logic                             axis_o_tlast,
    output logic [AXIS_BYTES-1:0]            axis_o_tkeep,
    output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]        axis_o_tuser
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int HW = HEADER_LENGTH_BYTES * 8;
    localparam int R  = HEADER_LENGTH_BYTES % AXIS_BYTES;   // residue bytes
    localparam int F  = HEADER_LENGTH_BYTES / AXIS_BYTES;   // full header words
    localparam int NW = F + 1;                              // words incl. partial
    localparam int CW = ($clog2(F + 1) > 1) ? $clog2(F + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_FLUSH
    } state_t;

    state_t                    state_reg, state_next;
    logic [HW-1:0]             hdr_reg, hdr_next;
    logic [CW-1:0]             ctr_reg, ctr_next;
    logic [AXIS_USER_BITS-1:0] last_user_reg, last_user_next;

    logic                      o_valid_reg, o_valid_next;
    logic                      o_last_reg, o_last_next;
    logic [AXIS_BYTES-1:0]     o_keep_reg, o_keep_next;
    logic [DW-1:0]             o_data_reg, o_data_next;
    logic [AXIS_USER_BITS-1:0] o_user_reg, o_user_next;

    logic                      load_en;
    logic                      hdr_hs;
    logic                      pay_hs;

    // In IDLE the header is read straight off the input so that the first
    // header beat can be loaded in the same cycle it is accepted.
    logic [HW-1:0]             hdr_src;
    logic [NW*DW-1:0]          hdr_pad;
    logic [DW-1:0]             hdr_words [NW];

    logic [DW-1:0]             merged_data;
    logic [AXIS_BYTES-1:0]     merged_keep;
    logic                      spill;
    logic [DW-1:0]             flush_data;
    logic [AXIS_BYTES-1:0]     flush_keep;

    assign hdr_src = (state_reg == ST_IDLE) ? header_i_tdata : hdr_reg;
    assign hdr_pad = {{(NW * DW - HW){1'b0}}, hdr_src};

    // Word F holds the partial tail of the header (residue source).
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_hdr_words
            assign hdr_words[gi] = hdr_pad[gi*DW +: DW];
        end
    endgenerate

    assign load_en         = !o_valid_reg || axis_o_tready;
    assign header_i_tready = sresetn && (state_reg == ST_IDLE);
    assign axis_i_tready   = sresetn && (state_reg == ST_DATA) && load_en;
    assign hdr_hs          = header_i_tvalid && header_i_tready;
    assign pay_hs          = axis_i_tvalid && axis_i_tready;

    axis_byte_realigner #(
        .AXIS_BYTES  (AXIS_BYTES),
        .SHIFT_BYTES (R)
    ) u_realigner (
        .clk          (clk),
        .sresetn      (sresetn),
        .preload      (hdr_hs),
        .preload_data (hdr_words[F]),
        .advance      (pay_hs),
        .in_data      (axis_i_tdata),
        .in_keep      (axis_i_tkeep),
        .merged_data  (merged_data),
        .merged_keep  (merged_keep),
        .spill        (spill),
        .flush_data   (flush_data),
        .flush_keep   (flush_keep)
    );

    always_comb begin
        state_next     = state_reg;
        hdr_next       = hdr_reg;
        ctr_next       = ctr_reg;
        last_user_next = last_user_reg;
        // A consumed beat drops valid; the payload fields stay as they were.
        o_valid_next   = o_valid_reg && !axis_o_tready;
        o_last_next    = o_last_reg;
        o_keep_next    = o_keep_reg;
        o_data_next    = o_data_reg;
        o_user_next    = o_user_reg;

        case (state_reg)
            ST_IDLE: begin
                if (hdr_hs) begin
                    hdr_next = header_i_tdata;
                    ctr_next = '0;
                    if (F == 0) begin
                        // Header fits entirely in the residue.
                        state_next = ST_DATA;
                    end else if (load_en) begin
                        o_valid_next = 1'b1;
                        o_data_next  = hdr_words[0];
                        o_keep_next  = {AXIS_BYTES{1'b1}};
                        o_last_next  = 1'b0;
                        o_user_next  = '0;
                        if (F == 1) begin
                            state_next = ST_DATA;
                        end else begin
                            ctr_next   = CW'(1);
                            state_next = ST_HDR;
                        end
                    end else begin
                        // Previous packet's last beat still stalled; emit
                        // header word 0 from the latched copy.
                        state_next = ST_HDR;
                    end
                end
            end

            ST_HDR: begin
                if (load_en) begin
                    o_valid_next = 1'b1;
                    o_data_next  = hdr_words[ctr_reg];
                    o_keep_next  = {AXIS_BYTES{1'b1}};
                    o_last_next  = 1'b0;
                    o_user_next  = '0;
                    if (ctr_reg == CW'(F - 1)) begin
                        ctr_next   = '0;
                        state_next = ST_DATA;
                    end else begin
                        ctr_next = ctr_reg + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (pay_hs) begin
                    o_valid_next = 1'b1;
                    o_data_next  = merged_data;
                    o_keep_next  = merged_keep;
                    o_user_next  = axis_i_tuser;
                    o_last_next  = axis_i_tlast && !spill;
                    if (axis_i_tlast) begin
                        if (spill) begin
                            last_user_next = axis_i_tuser;
                            state_next     = ST_FLUSH;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                if (load_en) begin
                    o_valid_next = 1'b1;
                    o_data_next  = flush_data;
                    o_keep_next  = flush_keep;
                    o_last_next  = 1'b1;
                    o_user_next  = last_user_reg;
                    state_next   = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_reg     <= ST_IDLE;
            hdr_reg       <= '0;
            ctr_reg       <= '0;
            last_user_reg <= '0;
            o_valid_reg   <= 1'b0;
            o_last_reg    <= 1'b0;
            o_keep_reg    <= '0;
            o_data_reg    <= '0;
            o_user_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            hdr_reg       <= hdr_next;
            ctr_reg       <= ctr_next;
            last_user_reg <= last_user_next;
            o_valid_reg   <= o_valid_next;
            o_last_reg    <= o_last_next;
            o_keep_reg    <= o_keep_next;
            o_data_reg    <= o_data_next;
            o_user_reg    <= o_user_next;
        end
    end

    assign axis_o_tvalid = o_valid_reg;
    assign axis_o_tlast  = o_last_reg;
    assign axis_o_tkeep  = o_keep_reg;
    assign axis_o_tdata  = o_data_reg;
    assign axis_o_tuser  = o_user_reg;

endmodule
